instr_queue: RTL and testbench

Circular instruction queue between the decode stage and the backend rename/dispatch stage. Decode writes up to IN_WIDTH decoded uops per cycle; the backend reads up to OUT_WIDTH per cycle in program order from the head. Reads are first-word-fall-through. A misprediction flush empties the queue in one cycle.

---
 rtl/instr_queue.sv | 90 +++++++++
 tb/tb_instr_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Circular decode-to-dispatch instruction queue: multi-lane enqueue at the
// tail, first-word-fall-through multi-lane dequeue at the head, and a
// single-cycle misprediction flush.
module instr_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned UOP_WIDTH = 128,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned ECW      = $clog2(IN_WIDTH + 1),
  localparam int unsigned DCW      = $clog2(OUT_WIDTH + 1)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_N_in,
  input  logic                                 flush_in,
  input  logic                                 enq_valid_in,
  input  logic [ECW-1:0]                       enq_count_in,
  input  logic [IN_WIDTH-1:0][UOP_WIDTH-1:0]   enq_uops_in,
  output logic                                 enq_ready_out,
  output logic [OUT_WIDTH-1:0][UOP_WIDTH-1:0]  deq_uops_out,
  output logic [OUT_WIDTH-1:0]                 deq_valid_out,
  input  logic [DCW-1:0]                       deq_count_in,
  output logic [CNT_W-1:0]                     count_out
);

  logic [UOP_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ECW-1:0]   enq_amt;
  logic             enq_fire;
  logic [CNT_W-1:0] e_amt;
  logic [CNT_W-1:0] d_amt;

  // Conservative ready: only the registered occupancy is considered.
  assign enq_ready_out = (count_q <= CNT_W'(DEPTH - IN_WIDTH));
  assign count_out     = count_q;

  // Next-state for pointers and occupancy; flush overrides enqueue/dequeue.
  always_comb begin
    enq_amt  = (enq_count_in > ECW'(IN_WIDTH)) ? ECW'(IN_WIDTH) : enq_count_in;
    enq_fire = enq_valid_in && enq_ready_out && !flush_in;
    e_amt    = enq_fire ? CNT_W'(enq_amt) : '0;
    d_amt    = (CNT_W'(deq_count_in) > count_q) ? count_q : CNT_W'(deq_count_in);
    head_d   = head_q + PTR_W'(d_amt);
    tail_d   = tail_q + PTR_W'(e_amt);
    count_d  = count_q + e_amt - d_amt;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage writes; entries are never cleared, only overwritten.
  always_ff @(posedge clk_in) begin
    for (int j = 0; j < IN_WIDTH; j++) begin
      if (enq_fire && (ECW'(j) < enq_amt)) begin
        mem[tail_q + PTR_W'(j)] <= enq_uops_in[j];
      end
    end
  end

  // Head lanes fall through directly from storage.
  always_comb begin
    deq_valid_out = '0;
    deq_uops_out  = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      deq_valid_out[i] = (CNT_W'(i) < count_q);
      deq_uops_out[i]  = mem[head_q + PTR_W'(i)];
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with hand-computed expected values.
module tb_instr_queue;

  logic                  clk_in = 1'b0;
  logic                  rst_N_in;
  logic                  flush_in;
  logic                  enq_valid_in;
  logic [2:0]            enq_count_in;
  logic [3:0][127:0]     enq_uops_in;
  logic                  enq_ready_out;
  logic [1:0][127:0]     deq_uops_out;
  logic [1:0]            deq_valid_out;
  logic [1:0]            deq_count_in;
  logic [4:0]            count_out;

  int n_vec = 0;
  int n_err = 0;

  instr_queue dut (
    .clk_in        (clk_in),
    .rst_N_in      (rst_N_in),
    .flush_in      (flush_in),
    .enq_valid_in  (enq_valid_in),
    .enq_count_in  (enq_count_in),
    .enq_uops_in   (enq_uops_in),
    .enq_ready_out (enq_ready_out),
    .deq_uops_out  (deq_uops_out),
    .deq_valid_out (deq_valid_out),
    .deq_count_in  (deq_count_in),
    .count_out     (count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [127:0] mk(input int k);
    return {32'hC0DE0000, 64'h0123456789ABCDEF, 32'(k)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n, input int base, input int dq, input logic fl);
    enq_valid_in = v;
    enq_count_in = 3'(n);
    for (int j = 0; j < 4; j++) enq_uops_in[j] = mk(base + j);
    deq_count_in = 2'(dq);
    flush_in     = fl;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cycle(input logic v, input int n, input int base, input int dq, input logic fl);
    drive(v, n, base, dq, fl);
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  int exp_seq[16] = '{11, 12, 13, 20, 21, 22, 23, 30, 31, 32, 33, 40, 50, 51, 52, 53};

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0);
    rst_N_in = 1'b0;
    #12;
    check("rst_count", 128'(count_out), 128'(0));
    check("rst_valid", 128'(deq_valid_out), 128'(0));
    check("rst_ready", 128'(enq_ready_out), 128'(1));
    rst_N_in = 1'b1;
    step();

    // Enqueue A,B,C; nothing visible before the edge.
    drive(1'b1, 3, 1, 0, 1'b0);
    #1;
    check("no_bypass", 128'(deq_valid_out), 128'(0));
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
    check("abc_count", 128'(count_out), 128'(3));
    check("abc_valid", 128'(deq_valid_out), 128'(2'b11));
    check("abc_lane0", deq_uops_out[0], mk(1));
    check("abc_lane1", deq_uops_out[1], mk(2));
    cycle(1'b0, 0, 0, 2, 1'b0);
    check("pop2_lane0", deq_uops_out[0], mk(3));
    check("pop2_valid", 128'(deq_valid_out), 128'(2'b01));
    cycle(1'b0, 0, 0, 1, 1'b0);
    check("pop1_count", 128'(count_out), 128'(0));

    // Fill to 13, stall a full group, release it with one dequeue.
    cycle(1'b1, 4, 10, 0, 1'b0);
    cycle(1'b1, 4, 20, 0, 1'b0);
    cycle(1'b1, 4, 30, 0, 1'b0);
    check("fill12_ready", 128'(enq_ready_out), 128'(1));
    cycle(1'b1, 1, 40, 0, 1'b0);
    check("fill13_count", 128'(count_out), 128'(13));
    check("fill13_ready", 128'(enq_ready_out), 128'(0));
    drive(1'b1, 4, 50, 0, 1'b0);
    step();
    check("stall_count", 128'(count_out), 128'(13));
    deq_count_in = 2'd1;
    step();
    deq_count_in = 2'd0;
    check("release_count", 128'(count_out), 128'(12));
    check("release_ready", 128'(enq_ready_out), 128'(1));
    check("release_lane0", deq_uops_out[0], mk(11));
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
    check("full_count", 128'(count_out), 128'(16));
    check("full_ready", 128'(enq_ready_out), 128'(0));
    for (int k = 0; k < 16; k += 2) begin
      check("drain_lane0", deq_uops_out[0], mk(exp_seq[k]));
      check("drain_lane1", deq_uops_out[1], mk(exp_seq[k + 1]));
      cycle(1'b0, 0, 0, 2, 1'b0);
    end
    check("drain_empty", 128'(count_out), 128'(0));

    // Move head and tail from 4 to 14.
    cycle(1'b1, 4, 500, 0, 1'b0);
    cycle(1'b1, 4, 510, 2, 1'b0);
    cycle(1'b1, 2, 520, 2, 1'b0);
    cycle(1'b0, 0, 0, 2, 1'b0);
    cycle(1'b0, 0, 0, 2, 1'b0);
    cycle(1'b0, 0, 0, 2, 1'b0);
    check("pre_wrap_count", 128'(count_out), 128'(0));

    // Group straddling index 15 -> 0.
    cycle(1'b1, 4, 60, 0, 1'b0);
    check("wrap_count", 128'(count_out), 128'(4));
    check("wrap_lane0", deq_uops_out[0], mk(60));
    check("wrap_lane1", deq_uops_out[1], mk(61));
    cycle(1'b0, 0, 0, 2, 1'b0);
    check("wrap_lane0b", deq_uops_out[0], mk(62));
    check("wrap_lane1b", deq_uops_out[1], mk(63));
    cycle(1'b0, 0, 0, 2, 1'b0);
    check("wrap_empty", 128'(deq_valid_out), 128'(0));
    cycle(1'b1, 1, 70, 0, 1'b0);
    check("wrap_tail2", deq_uops_out[0], mk(70));

    // Simultaneous enqueue and dequeue from count 5.
    cycle(1'b1, 4, 80, 0, 1'b0);
    check("sim_pre", 128'(count_out), 128'(5));
    cycle(1'b1, 4, 90, 2, 1'b0);
    check("sim_count", 128'(count_out), 128'(7));
    check("sim_lane0", deq_uops_out[0], mk(81));
    check("sim_lane1", deq_uops_out[1], mk(82));

    // Flush with count 9 and a concurrent enqueue.
    cycle(1'b1, 2, 100, 0, 1'b0);
    check("flush_pre", 128'(count_out), 128'(9));
    cycle(1'b1, 4, 200, 1, 1'b1);
    check("flush_count", 128'(count_out), 128'(0));
    check("flush_valid", 128'(deq_valid_out), 128'(0));
    check("flush_ready", 128'(enq_ready_out), 128'(1));
    cycle(1'b1, 1, 300, 0, 1'b0);
    check("post_flush_lane0", deq_uops_out[0], mk(300));
    check("post_flush_valid", 128'(deq_valid_out), 128'(2'b01));

    // Flush while enqueue is blocked.
    cycle(1'b1, 4, 310, 0, 1'b0);
    cycle(1'b1, 4, 320, 0, 1'b0);
    cycle(1'b1, 4, 330, 0, 1'b0);
    check("blocked_ready", 128'(enq_ready_out), 128'(0));
    cycle(1'b0, 0, 0, 0, 1'b1);
    check("blocked_flush_cnt", 128'(count_out), 128'(0));
    check("blocked_flush_rdy", 128'(enq_ready_out), 128'(1));

    // Over-dequeue from count 1.
    cycle(1'b1, 1, 400, 0, 1'b0);
    cycle(1'b0, 0, 0, 2, 1'b0);
    check("overdeq_count", 128'(count_out), 128'(0));
    check("overdeq_valid", 128'(deq_valid_out), 128'(0));
    cycle(1'b1, 1, 401, 0, 1'b0);
    check("overdeq_head", deq_uops_out[0], mk(401));

    // Count above IN_WIDTH clamps to a full group; count 0 is a no-op.
    cycle(1'b1, 7, 410, 0, 1'b0);
    check("clamp_count", 128'(count_out), 128'(5));
    check("clamp_lane1", deq_uops_out[1], mk(410));
    cycle(1'b1, 0, 420, 0, 1'b0);
    check("zero_enq", 128'(count_out), 128'(5));

    // Asynchronous reset mid-cycle with count 6.
    cycle(1'b1, 1, 430, 0, 1'b0);
    check("pre_rst_count", 128'(count_out), 128'(6));
    #2;
    rst_N_in = 1'b0;
    #1;
    check("async_count", 128'(count_out), 128'(0));
    check("async_valid", 128'(deq_valid_out), 128'(0));
    check("async_ready", 128'(enq_ready_out), 128'(1));
    step();
    rst_N_in = 1'b1;
    step();
    check("post_rst_count", 128'(count_out), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
